// File: rtl/stopwatch.sv
// Count-up stopwatch with millisecond resolution and lap (split) capture.
// Two button levels drive a four-state controller (IDLE/RUN/LAP/PAUSE).
// Time saturates at (MAX_MIN-1):59.999 and sets a sticky ovf flag.
// Optional lap counter output enabled by defining STOPWATCH_LAP_COUNT_EN.
module stopwatch #(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned MAX_MIN  = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        lap_reset,
    output logic [6:0]  min,
    output logic [6:0]  sec,
    output logic [14:0] msec,
    output logic        running,
    output logic        lap_active,
`ifdef STOPWATCH_LAP_COUNT_EN
    output logic        ovf,
    output logic [6:0]  lap_cnt
`else
    output logic        ovf
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);
    localparam logic [6:0]  MIN_LAST = 7'(MAX_MIN - 1);

    state_t      state_q, state_d;
    logic        ss_prev_q, lr_prev_q;
    logic [15:0] div_q, div_d;
    logic [6:0]  live_min_q, live_min_d;
    logic [5:0]  live_sec_q, live_sec_d;
    logic [9:0]  live_ms_q, live_ms_d;
    logic [6:0]  cap_min_q, cap_min_d;
    logic [5:0]  cap_sec_q, cap_sec_d;
    logic [9:0]  cap_ms_q, cap_ms_d;
    logic        ovf_q, ovf_d;
    logic [6:0]  disp_min_q;
    logic [6:0]  disp_sec_q;
    logic [14:0] disp_ms_q;
    logic        running_q, lap_active_q;

    logic ss_ev, lr_ev, counting, tick, at_max, capture, clear_all;

    // Button events; start_stop wins when both rise together.
    always_comb begin
        ss_ev    = start_stop & ~ss_prev_q;
        lr_ev    = lap_reset & ~lr_prev_q & ~ss_ev;
        counting = (state_q == RUN) || (state_q == LAP);
        tick     = counting && (div_q == DIV_LAST);
        at_max   = (live_min_q == MIN_LAST) && (live_sec_q == 6'd59) && (live_ms_q == 10'd999);
    end

    // Next-state, divider, live count and capture logic.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        live_min_d = live_min_q;
        live_sec_d = live_sec_q;
        live_ms_d  = live_ms_q;
        cap_min_d  = cap_min_q;
        cap_sec_d  = cap_sec_q;
        cap_ms_d   = cap_ms_q;
        ovf_d      = ovf_q;
        capture    = 1'b0;
        clear_all  = 1'b0;

        if (counting) begin
            div_d = tick ? 16'd0 : div_q + 16'd1;
        end

        // The saturating tick leaves the count untouched; the controller pauses below.
        if (tick) begin
            if (at_max) begin
                ovf_d = 1'b1;
            end else if (live_ms_q == 10'd999) begin
                live_ms_d = 10'd0;
                if (live_sec_q == 6'd59) begin
                    live_sec_d = 6'd0;
                    live_min_d = live_min_q + 7'd1;
                end else begin
                    live_sec_d = live_sec_q + 6'd1;
                end
            end else begin
                live_ms_d = live_ms_q + 10'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (ss_ev) state_d = RUN;
            end
            RUN: begin
                if (ss_ev) begin
                    state_d = PAUSE;
                end else if (lr_ev) begin
                    state_d = LAP;
                    capture = 1'b1;
                end
            end
            LAP: begin
                if (ss_ev) begin
                    state_d = PAUSE;
                end else if (lr_ev) begin
                    capture = 1'b1;
                end
            end
            PAUSE: begin
                if (ss_ev) begin
                    if (!ovf_q) state_d = RUN;
                end else if (lr_ev) begin
                    state_d   = IDLE;
                    clear_all = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Capture takes the live value as it stood before this cycle's tick.
        if (capture) begin
            cap_min_d = live_min_q;
            cap_sec_d = live_sec_q;
            cap_ms_d  = live_ms_q;
        end

        if (tick && at_max) begin
            state_d = PAUSE;
        end

        if (clear_all) begin
            div_d      = 16'd0;
            live_min_d = 7'd0;
            live_sec_d = 6'd0;
            live_ms_d  = 10'd0;
            cap_min_d  = 7'd0;
            cap_sec_d  = 6'd0;
            cap_ms_d   = 10'd0;
            ovf_d      = 1'b0;
        end
    end

    // Button history follows the pins even during reset, so a held button makes no event.
    always_ff @(posedge clk) begin
        ss_prev_q <= start_stop;
        lr_prev_q <= lap_reset;
    end

    // Controller, divider and counter state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            div_q      <= 16'd0;
            live_min_q <= 7'd0;
            live_sec_q <= 6'd0;
            live_ms_q  <= 10'd0;
            cap_min_q  <= 7'd0;
            cap_sec_q  <= 6'd0;
            cap_ms_q   <= 10'd0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            live_min_q <= live_min_d;
            live_sec_q <= live_sec_d;
            live_ms_q  <= live_ms_d;
            cap_min_q  <= cap_min_d;
            cap_sec_q  <= cap_sec_d;
            cap_ms_q   <= cap_ms_d;
            ovf_q      <= ovf_d;
        end
    end

    // Registered display mux and status flags, one cycle behind the controller.
    always_ff @(posedge clk) begin
        if (!rst) begin
            disp_min_q   <= 7'd0;
            disp_sec_q   <= 7'd0;
            disp_ms_q    <= 15'd0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
        end else begin
            running_q    <= counting;
            lap_active_q <= (state_q == LAP);
            if (state_q == LAP) begin
                disp_min_q <= cap_min_q;
                disp_sec_q <= {1'b0, cap_sec_q};
                disp_ms_q  <= {5'd0, cap_ms_q};
            end else begin
                disp_min_q <= live_min_q;
                disp_sec_q <= {1'b0, live_sec_q};
                disp_ms_q  <= {5'd0, live_ms_q};
            end
        end
    end

    assign min        = disp_min_q;
    assign sec        = disp_sec_q;
    assign msec       = disp_ms_q;
    assign running    = running_q;
    assign lap_active = lap_active_q;
    assign ovf        = ovf_q;

`ifdef STOPWATCH_LAP_COUNT_EN
    logic [6:0] lapn_q, lapn_d;

    // Lap counter saturates at 99 and clears with the rest of the count.
    always_comb begin
        lapn_d = lapn_q;
        if (clear_all) begin
            lapn_d = 7'd0;
        end else if (capture && (lapn_q != 7'd99)) begin
            lapn_d = lapn_q + 7'd1;
        end
    end

    // Lap counter register.
    always_ff @(posedge clk) begin
        if (!rst) lapn_q <= 7'd0;
        else      lapn_q <= lapn_d;
    end

    assign lap_cnt = lapn_q;
`endif

endmodule
